expr_sequencer: RTL

//   Shares one infix->postfix converter (conv) + postfix evaluator (man) chain between two

---
 rtl/expr_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/expr_sequencer.sv
// expr_sequencer: shares one infix->postfix converter + postfix evaluator chain
// between two token requesters. The chain is locked to one requester for a
// whole expression (round-robin on contention). Tokens are forwarded one at a
// time with the converter STB/BUSY handshake, the end marker is issued, and the
// evaluator result (or a timeout error) is returned to the owner.
//
// Ports
//   CLK, RST          clock, synchronous active-low reset
//   REQ/GNT           per-requester slot request / one-hot grant
//   TOK_*             per-requester token stream, TOK_ACK pulses on capture
//   RES_*             shared result bus, RES_STB held per owner until RES_ACK
//   INPUT_SIGN/SIGN_STB, INPUT_NUMBER/NUMBER_STB, CONV_BUSY   converter side
//   EVAL_READY/EVAL_OUT                                       evaluator side
module expr_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RES_W  = 32,
    parameter int unsigned TMO    = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            REQ,
    output logic [1:0]            GNT,
    input  logic [1:0]            TOK_STB,
    input  logic [1:0]            TOK_IS_SIGN,
    input  logic [2*DATA_W-1:0]   TOK_DATA,
    input  logic [1:0]            TOK_LAST,
    output logic [1:0]            TOK_ACK,
    output logic [RES_W-1:0]      RES_DATA,
    output logic                  RES_ERR,
    output logic [1:0]            RES_STB,
    input  logic [1:0]            RES_ACK,
    output logic [DATA_W-1:0]     INPUT_SIGN,
    output logic                  SIGN_STB,
    output logic [DATA_W-1:0]     INPUT_NUMBER,
    output logic                  NUMBER_STB,
    input  logic                  CONV_BUSY,
    input  logic                  EVAL_READY,
    input  logic [RES_W-1:0]      EVAL_OUT
);

    localparam int unsigned CNT_W = $clog2(TMO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_ISSUE,
        S_FLUSH,
        S_WAIT_RES,
        S_RETURN
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                rr_q, rr_d;
    logic [1:0]          tok_ack_q, tok_ack_d;
    logic                tok_is_sign_q, tok_is_sign_d;
    logic [DATA_W-1:0]   tok_data_q, tok_data_d;
    logic                tok_last_q, tok_last_d;
    logic                sign_stb_q, sign_stb_d;
    logic                number_stb_q, number_stb_d;
    logic [DATA_W-1:0]   input_sign_q, input_sign_d;
    logic [DATA_W-1:0]   input_number_q, input_number_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0]    res_data_q, res_data_d;
    logic                res_err_q, res_err_d;
    logic [1:0]          res_stb_q, res_stb_d;

    logic                owner_c;
    logic                grant_idx_c;
    logic                stb_active_c;
    logic [DATA_W-1:0]   owner_data_c;

    // Owner index is the upper grant bit; only meaningful while granted.
    assign owner_c      = gnt_q[1];
    assign stb_active_c = sign_stb_q | number_stb_q;
    assign owner_data_c = owner_c ? TOK_DATA[DATA_W +: DATA_W] : TOK_DATA[0 +: DATA_W];

    // Next-state and output computation.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        rr_d           = rr_q;
        tok_ack_d      = 2'b00;
        tok_is_sign_d  = tok_is_sign_q;
        tok_data_d     = tok_data_q;
        tok_last_d     = tok_last_q;
        sign_stb_d     = sign_stb_q;
        number_stb_d   = number_stb_q;
        input_sign_d   = input_sign_q;
        input_number_d = input_number_q;
        cnt_d          = cnt_q;
        res_data_d     = res_data_q;
        res_err_d      = res_err_q;
        res_stb_d      = res_stb_q;
        grant_idx_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    // On contention the requester that did not win last time goes first.
                    grant_idx_c = (REQ == 2'b11) ? ~rr_q : REQ[1];
                    gnt_d       = grant_idx_c ? 2'b10 : 2'b01;
                    rr_d        = grant_idx_c;
                    state_d     = S_FEED;
                end
            end

            S_FEED: begin
                if (TOK_STB[owner_c]) begin
                    tok_is_sign_d = TOK_IS_SIGN[owner_c];
                    tok_data_d    = owner_data_c;
                    tok_last_d    = TOK_LAST[owner_c];
                    tok_ack_d     = owner_c ? 2'b10 : 2'b01;
                    state_d       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Strobe is raised only once the converter is idle and held until it
                // reports BUSY, which is the converter's acknowledgement.
                if (stb_active_c) begin
                    if (CONV_BUSY) begin
                        sign_stb_d   = 1'b0;
                        number_stb_d = 1'b0;
                        state_d      = tok_last_q ? S_FLUSH : S_FEED;
                    end
                end else if (!CONV_BUSY) begin
                    if (tok_is_sign_q) begin
                        sign_stb_d   = 1'b1;
                        input_sign_d = tok_data_q;
                    end else begin
                        number_stb_d   = 1'b1;
                        input_number_d = tok_data_q;
                    end
                end
            end

            S_FLUSH: begin
                // End-of-expression marker: both strobes in the same cycle.
                if (stb_active_c) begin
                    if (CONV_BUSY) begin
                        sign_stb_d   = 1'b0;
                        number_stb_d = 1'b0;
                        cnt_d        = '0;
                        state_d      = S_WAIT_RES;
                    end
                end else if (!CONV_BUSY) begin
                    sign_stb_d   = 1'b1;
                    number_stb_d = 1'b1;
                end
            end

            S_WAIT_RES: begin
                // A ready result takes priority over a timeout in the same cycle.
                if (EVAL_READY) begin
                    res_data_d = EVAL_OUT;
                    res_err_d  = 1'b0;
                    res_stb_d  = gnt_q;
                    state_d    = S_RETURN;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    res_stb_d  = gnt_q;
                    state_d    = S_RETURN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RETURN: begin
                if (|(RES_ACK & res_stb_q)) begin
                    res_stb_d = 2'b00;
                    gnt_d     = 2'b00;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q        <= S_IDLE;
            gnt_q          <= 2'b00;
            rr_q           <= 1'b1;
            tok_ack_q      <= 2'b00;
            tok_is_sign_q  <= 1'b0;
            tok_data_q     <= '0;
            tok_last_q     <= 1'b0;
            sign_stb_q     <= 1'b0;
            number_stb_q   <= 1'b0;
            input_sign_q   <= '0;
            input_number_q <= '0;
            cnt_q          <= '0;
            res_data_q     <= '0;
            res_err_q      <= 1'b0;
            res_stb_q      <= 2'b00;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            rr_q           <= rr_d;
            tok_ack_q      <= tok_ack_d;
            tok_is_sign_q  <= tok_is_sign_d;
            tok_data_q     <= tok_data_d;
            tok_last_q     <= tok_last_d;
            sign_stb_q     <= sign_stb_d;
            number_stb_q   <= number_stb_d;
            input_sign_q   <= input_sign_d;
            input_number_q <= input_number_d;
            cnt_q          <= cnt_d;
            res_data_q     <= res_data_d;
            res_err_q      <= res_err_d;
            res_stb_q      <= res_stb_d;
        end
    end

    assign GNT          = gnt_q;
    assign TOK_ACK      = tok_ack_q;
    assign RES_DATA     = res_data_q;
    assign RES_ERR      = res_err_q;
    assign RES_STB      = res_stb_q;
    assign INPUT_SIGN   = input_sign_q;
    assign SIGN_STB     = sign_stb_q;
    assign INPUT_NUMBER = input_number_q;
    assign NUMBER_STB   = number_stb_q;

endmodule
